mem_wb_skid: RTL

- Parametrised MEM/WB pipeline register with a valid/ready handshake and a one-entry skid buffer.
- Sits between the data-memory stage and write-back; a stalled write-back port (out_ready=0) never combinationally reaches the MEM stage.
- Adds a flush, per-entry valid bits, an r0-write guard and a muxed write-back data output.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_skid_buf.sv | 115 +++++++++++
 rtl/mem_wb_skid.sv | 73 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register package.
// Holds default field widths, the MEM/WB payload layout used by the stage registers,
// the skid-buffer state encoding and a helper that sizes a flattened MEM/WB payload.
package pipe_pkg;

    localparam int unsigned DEFAULT_DATA_W     = 32;
    localparam int unsigned DEFAULT_REG_ADDR_W = 5;

    // MEM/WB payload at the default widths; field order matches the flattened vector
    // built by mem_wb_skid (regwrite is the MSB, reg_dest the LSBs).
    typedef struct packed {
        logic                          regwrite;
        logic                          memtoreg;
        logic [DEFAULT_DATA_W-1:0]     read_data;
        logic [DEFAULT_DATA_W-1:0]     result;
        logic [DEFAULT_REG_ADDR_W-1:0] reg_dest;
    } mem_wb_t;

    // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } skid_state_e;

    function automatic int unsigned mem_wb_payload_w(int unsigned data_w, int unsigned addr_w);
        return 2 + 2 * data_w + addr_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer.
// The main entry drives the outputs; the skid entry catches the one transfer that
// arrives while the consumer stalls, so in_ready is a pure register output and never
// depends combinationally on out_ready.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   flush               synchronous kill of both entries (same-cycle accept discarded)
//   in_valid/in_ready   producer handshake, in_data payload
//   out_valid/out_ready consumer handshake, out_data payload (main entry)
//   occupancy           number of entries held (0..2)
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
);

    skid_state_e state_q, state_d;

    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 load_main;
    logic                 load_skid;
    logic                 main_from_skid;
    logic                 accept;
    logic                 drain;

    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        occupancy      = 2'd0;

        unique case (state_q)
            StEmpty: begin
                occupancy = 2'd0;
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = StOne;
                end
            end
            StOne: begin
                occupancy = 2'd1;
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = StFull;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                occupancy = 2'd2;
                if (drain) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase

        // Flush overrides everything; payload loads are harmless since valids clear.
        if (flush) begin
            state_d   = StEmpty;
            load_main = 1'b0;
            load_skid = 1'b0;
        end

        main_d = main_from_skid ? skid_q : in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_d;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with valid/ready handshake and one-entry skid buffer.
// Wraps pipe_skid_buf around the flattened MEM/WB payload and adds the write-back
// data mux and the register-write enable, optionally suppressing writes to r0.
// Ports:
//   clk, reset, flush                 clock, async active-high reset, synchronous kill
//   in_valid/in_ready                 handshake with the MEM stage
//   regwrite_in .. reg_dest_in        payload from EX/MEM and data memory
//   out_valid/out_ready               handshake with write-back
//   regwrite_out .. reg_dest_out      head-entry payload
//   wb_data                           memtoreg_out ? read_data_out : result_out
//   wb_we                             register-file write enable for this cycle
//   occupancy                         entries held (0..2)
module mem_wb_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned REG_ADDR_W     = DEFAULT_REG_ADDR_W,
    parameter bit          ZERO_REG_GUARD = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  regwrite_in,
    input  logic                  memtoreg_in,
    input  logic [DATA_W-1:0]     read_data_in,
    input  logic [DATA_W-1:0]     result_in,
    input  logic [REG_ADDR_W-1:0] reg_dest_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  regwrite_out,
    output logic                  memtoreg_out,
    output logic [DATA_W-1:0]     read_data_out,
    output logic [DATA_W-1:0]     result_out,
    output logic [REG_ADDR_W-1:0] reg_dest_out,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_we,
    output logic [1:0]            occupancy
);

    localparam int unsigned PAYLOAD_W = mem_wb_payload_w(DATA_W, REG_ADDR_W);

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 dest_ok;

    assign in_payload = {regwrite_in, memtoreg_in, read_data_in, result_in, reg_dest_in};

    pipe_skid_buf #(
        .PAYLOAD_W(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload),
        .occupancy(occupancy)
    );

    assign {regwrite_out, memtoreg_out, read_data_out, result_out, reg_dest_out} = out_payload;

    assign wb_data = memtoreg_out ? read_data_out : result_out;

    // Payload still passes through for dest 0; only the write enable is suppressed.
    assign dest_ok = (reg_dest_out != '0) | ~ZERO_REG_GUARD;
    assign wb_we   = out_valid & out_ready & regwrite_out & dest_ok;

endmodule
